// File: rtl/mac_seq_ctrl_pkg.sv
// Shared constants, state encoding and width helpers for the MAC sequencing controller.
package mac_ctrl_pkg;
  localparam int LANES     = 16;
  localparam int PIX_W     = 8;
  localparam int VEC_W     = LANES * PIX_W;
  localparam int MAC_SUM_W = 20;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_e;

  function automatic int acc_width(input int n);
    return MAC_SUM_W + $clog2(n);
  endfunction

  // Chunk index width; a single-chunk kernel still gets a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Weight, pixel and result handshakes of the MAC sequencing controller.
interface mac_seq_ctrl_if #(parameter int ACC_W = 22);
  logic                           w_valid, w_ready;
  logic [mac_ctrl_pkg::VEC_W-1:0] w_data;
  logic                           px_valid, px_ready;
  logic [mac_ctrl_pkg::VEC_W-1:0] px_data;
  logic                           res_valid, res_ready;
  logic [ACC_W-1:0]               res_data;

  modport master (output w_valid, w_data, px_valid, px_data, res_ready,
                  input  w_ready, px_ready, res_valid, res_data);
  modport slave  (input  w_valid, w_data, px_valid, px_data, res_ready,
                  output w_ready, px_ready, res_valid, res_data);
endinterface

// File: rtl/mac_seq_ctrl_wbank.sv
// Kernel weight bank: one write port, one asynchronous read port, cleared by reset.
module mac_wbank import mac_ctrl_pkg::*; #(
  parameter int N_CHUNKS = 4,
  parameter int CW       = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [CW-1:0]    waddr,
  input  logic [VEC_W-1:0] wdata,
  input  logic [CW-1:0]    raddr,
  output logic [VEC_W-1:0] rdata
);
  logic [VEC_W-1:0] bank [N_CHUNKS];

  for (genvar e = 0; e < N_CHUNKS; e++) begin : g_ent
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)                        bank[e] <= '0;
      else if (we && waddr == CW'(e))    bank[e] <= wdata;
  end

  if (N_CHUNKS == 1) begin : g_one
    assign rdata = bank[0];
  end else begin : g_many
    assign rdata = bank[raddr];
  end
endmodule

// File: rtl/mac_seq_ctrl.sv
// Loads a kernel of weight chunks, streams pixel chunks through the external MAC
// datapath and accumulates the partial sums into one result per kernel.
module mac_seq_ctrl import mac_ctrl_pkg::*; #(
  parameter  int N_CHUNKS = 4,
  parameter  int ACC_W    = acc_width(N_CHUNKS),
  localparam int CW       = idx_width(N_CHUNKS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mac_seq_ctrl_if.slave        bus,
  input  logic                 reload,
  output logic [VEC_W-1:0]     mac_pixels,
  output logic [VEC_W-1:0]     mac_weights,
  input  logic [MAC_SUM_W-1:0] mac_sum,
  output logic                 busy,
  output logic [CW-1:0]        chunk_idx
);
  localparam logic [CW-1:0] LAST = CW'(N_CHUNKS - 1);

  state_e           state, state_nx;
  logic [CW-1:0]    w_cnt;
  logic             w_fire, px_fire, s1_v, s1_last, res_load, run_reload;
  logic [ACC_W-1:0] acc, acc_sum;
  logic [VEC_W-1:0] w_rd;

  assign w_fire     = bus.w_valid && bus.w_ready;
  assign px_fire    = bus.px_valid && bus.px_ready;
  assign res_load   = s1_v && s1_last;
  assign run_reload = (state == RUN) && reload;
  assign acc_sum    = acc + ACC_W'(mac_sum);
  assign busy       = (state != IDLE);

  mac_wbank #(.N_CHUNKS(N_CHUNKS), .CW(CW)) u_wbank (
    .clk(clk), .rst_n(rst_n), .we(w_fire && !reload), .waddr(w_cnt),
    .wdata(bus.w_data), .raddr(chunk_idx), .rdata(w_rd)
  );

  always_comb begin
    state_nx     = state;
    bus.w_ready  = 1'b0;
    bus.px_ready = 1'b0;
    case (state)
      IDLE: begin
        bus.w_ready = 1'b1;
        if (!reload && w_fire) state_nx = (N_CHUNKS == 1) ? RUN : LOAD;
      end
      LOAD: begin
        bus.w_ready = 1'b1;
        if (reload)                       state_nx = IDLE;
        else if (w_fire && w_cnt == LAST) state_nx = RUN;
      end
      RUN: begin
        // A pixel beat coinciding with reload is refused so nothing enters stage 1 while draining.
        bus.px_ready = !reload && !(s1_v && s1_last) && !(bus.res_valid && !bus.res_ready);
        if (reload) state_nx = DRAIN;
      end
      DRAIN:   if (!s1_v && !bus.res_valid) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      w_cnt <= '0;
    end else begin
      state <= state_nx;
      if (reload && (state == IDLE || state == LOAD)) w_cnt <= '0;
      else if (w_fire)                               w_cnt <= (w_cnt == LAST) ? '0 : w_cnt + 1'b1;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      chunk_idx   <= '0;
      s1_v        <= 1'b0;
      s1_last     <= 1'b0;
      mac_pixels  <= '0;
      mac_weights <= '0;
    end else begin
      s1_v    <= px_fire;
      s1_last <= px_fire && (chunk_idx == LAST);
      if (px_fire) begin
        mac_pixels  <= bus.px_data;
        mac_weights <= w_rd;
      end
      if (run_reload)   chunk_idx <= '0;
      else if (px_fire) chunk_idx <= (chunk_idx == LAST) ? '0 : chunk_idx + 1'b1;
    end

  // Stage 2: a finishing beat still produces its result on a reload edge,
  // while a non-finishing beat's contribution is dropped by the acc clear.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc           <= '0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
    end else begin
      if (res_load) begin
        bus.res_data  <= acc_sum;
        bus.res_valid <= 1'b1;
      end else if (bus.res_valid && bus.res_ready) begin
        bus.res_valid <= 1'b0;
      end
      if (res_load || run_reload) acc <= '0;
      else if (s1_v)              acc <= acc_sum;
    end
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: directed kernels plus randomized traffic against a kernel-level model.
module tb_mac_seq_ctrl;
  import mac_ctrl_pkg::*;
  localparam int N   = 4;
  localparam int AW  = acc_width(N);
  localparam int CW  = idx_width(N);
  localparam int AW1 = acc_width(1);

  logic clk = 1'b0, rst_n = 1'b0, reload = 1'b0, reload1 = 1'b0;
  always #5 clk = ~clk;

  mac_seq_ctrl_if #(.ACC_W(AW))  bus  ();
  mac_seq_ctrl_if #(.ACC_W(AW1)) bus1 ();
  logic [VEC_W-1:0]     mac_pixels, mac_weights, mac_pixels1, mac_weights1;
  logic [MAC_SUM_W-1:0] mac_sum, mac_sum1;
  logic                 busy, busy1;
  logic [CW-1:0]        chunk_idx;
  logic                 chunk_idx1;

  function automatic longint dotp(input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b);
    longint s = 0;
    for (int i = 0; i < LANES; i++)
      s += longint'(a[i*PIX_W +: PIX_W]) * longint'(b[i*PIX_W +: PIX_W]);
    return s;
  endfunction

  assign mac_sum  = MAC_SUM_W'(dotp(mac_pixels, mac_weights));
  assign mac_sum1 = MAC_SUM_W'(dotp(mac_pixels1, mac_weights1));

  mac_seq_ctrl #(.N_CHUNKS(N)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .reload(reload), .mac_pixels(mac_pixels),
    .mac_weights(mac_weights), .mac_sum(mac_sum), .busy(busy), .chunk_idx(chunk_idx));

  mac_seq_ctrl #(.N_CHUNKS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .reload(reload1), .mac_pixels(mac_pixels1),
    .mac_weights(mac_weights1), .mac_sum(mac_sum1), .busy(busy1), .chunk_idx(chunk_idx1));

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Kernel-level reference: collect weight chunks, sum dot products per kernel.
  logic [VEC_W-1:0] m_w [N];
  int     m_wc = 0, m_k = 0;
  longint m_part = 0, hold_d = 0;
  bit     m_run = 0, hold_p = 0;
  longint exp_q [$];

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_wc = 0; m_k = 0; m_part = 0; m_run = 0; hold_p = 0;
      exp_q.delete();
    end else begin
      chk("px_ready_outside_run", longint'(bus.px_ready && !m_run), 0);
      chk("w_ready_during_run", longint'(bus.w_ready && m_run), 0);
      if (hold_p) begin
        chk("res_hold_valid", bus.res_valid, 1);
        chk("res_hold_data", bus.res_data, hold_d);
      end
      hold_p = bus.res_valid && !bus.res_ready;
      hold_d = bus.res_data;
      if (bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) chk("res_unexpected", exp_q.size(), 1);
        else                   chk("res_data", bus.res_data, exp_q.pop_front());
      end
      if (reload) begin
        m_wc = 0;
        if (m_run) begin m_run = 0; m_k = 0; m_part = 0; end
      end else begin
        if (bus.w_valid && bus.w_ready) begin
          m_w[m_wc] = bus.w_data;
          m_wc++;
          if (m_wc == N) begin m_run = 1; m_wc = 0; end
        end
        if (bus.px_valid && bus.px_ready) begin
          m_part += dotp(bus.px_data, m_w[m_k]);
          m_k++;
          if (m_k == N) begin exp_q.push_back(m_part); m_part = 0; m_k = 0; end
        end
      end
    end
  end

  bit rnd_rr = 0;
  initial forever begin
    @(posedge clk); #1;
    if (rnd_rr) bus.res_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [VEC_W-1:0] kw [N];

  function automatic logic [VEC_W-1:0] rand_vec();
    logic [VEC_W-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*PIX_W +: PIX_W] = 8'($urandom_range(0, 255));
    return v;
  endfunction

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic send_w(input logic [VEC_W-1:0] d);
    int t = 0;
    bus.w_valid = 1'b1; bus.w_data = d;
    @(negedge clk);
    while (!bus.w_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) chk("w_accept_timeout", t, 0);
    tick(); bus.w_valid = 1'b0;
  endtask

  task automatic send_px(input logic [VEC_W-1:0] d, output int waited);
    int t = 0;
    bus.px_valid = 1'b1; bus.px_data = d;
    @(negedge clk);
    while (!bus.px_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) chk("px_accept_timeout", t, 0);
    waited = t;
    tick(); bus.px_valid = 1'b0;
  endtask

  task automatic pulse_reload(); reload = 1'b1; tick(); reload = 1'b0; endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 500) begin tick(); t++; end
    if (t >= 500) chk("idle_timeout", t, 0);
  endtask

  task automatic load_kernel();
    if (busy) pulse_reload();
    wait_idle();
    for (int k = 0; k < N; k++) send_w(kw[k]);
  endtask

  task automatic expect_res(input string tag, input longint v);
    int t = 0;
    while (!bus.res_valid && t < 50) begin tick(); t++; end
    if (t >= 50) chk({tag, "_timeout"}, t, 0);
    else         chk(tag, bus.res_data, v);
  endtask

  initial begin
    int w, tot, cnt, nb;
    bus.w_valid = 0; bus.w_data = '0; bus.px_valid = 0; bus.px_data = '0; bus.res_ready = 0;
    bus1.w_valid = 0; bus1.w_data = '0; bus1.px_valid = 0; bus1.px_data = '0; bus1.res_ready = 0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_px_ready", bus.px_ready, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_chunk_idx", chunk_idx, 0);
    chk("rst_mac_pixels", longint'(mac_pixels != '0), 0);
    @(negedge clk); rst_n = 1'b1; tick();
    chk("post_rst_w_ready", bus.w_ready, 1);
    chk("post_rst_busy", busy, 0);

    // Largest possible kernel result and the one-cycle result latency.
    bus.res_ready = 1'b1;
    for (int k = 0; k < N; k++) kw[k] = {LANES{8'hFF}};
    load_kernel();
    chk("max_busy", busy, 1);
    tot = 0;
    for (int b = 0; b < N; b++) begin send_px({LANES{8'hFF}}, w); tot += w; end
    chk("max_no_stall", tot, 0);
    chk("max_bubble_px_ready", bus.px_ready, 0);
    chk("max_lat_early", bus.res_valid, 0);
    tick();
    chk("max_lat", bus.res_valid, 1);
    chk("max_val", bus.res_data, 4161600);
    chk("max_px_ready_back", bus.px_ready, 1);

    // Chunk ordering: weight chunk k holds k+1 in every byte.
    for (int k = 0; k < N; k++) kw[k] = {LANES{8'(k + 1)}};
    load_kernel();
    for (int b = 0; b < N; b++) send_px({LANES{8'h02}}, w);
    expect_res("order_320", 320);
    for (int b = 0; b < N; b++) send_px({LANES{8'(b + 1)}}, w);
    expect_res("order_480", 480);

    // Result backpressure holds the stream until the consumer takes the first result.
    tick();
    bus.res_ready = 1'b0;
    fork
      begin
        int wb;
        for (int b = 0; b < 2*N; b++) send_px({LANES{8'h02}}, wb);
      end
      begin
        repeat (12) tick();
        chk("bp_valid", bus.res_valid, 1);
        chk("bp_data", bus.res_data, 320);
        chk("bp_px_ready", bus.px_ready, 0);
        chk("bp_chunk_idx", chunk_idx, 0);
        bus.res_ready = 1'b1;
      end
    join
    expect_res("bp_second", 320);

    // Reload halfway through a kernel, then a fresh kernel of ones.
    tick();
    for (int b = 0; b < 2; b++) send_px({LANES{8'h02}}, w);
    pulse_reload();
    chk("rl_drain_busy", busy, 1);
    chk("rl_chunk_idx", chunk_idx, 0);
    wait_idle();
    chk("rl_idle_busy", busy, 0);
    for (int k = 0; k < N; k++) kw[k] = {LANES{8'h01}};
    send_w(kw[0]);
    chk("rl_load_busy", busy, 1);
    for (int k = 1; k < N; k++) send_w(kw[k]);
    for (int b = 0; b < N; b++) send_px({LANES{8'h03}}, w);
    expect_res("rl_192", 192);

    // Random kernels, gaps, consumer stalls and reloads during LOAD and RUN.
    rnd_rr = 1;
    for (int it = 0; it < 10; it++) begin
      for (int k = 0; k < N; k++) kw[k] = rand_vec();
      if ($urandom_range(0, 3) == 0) begin
        if (busy) begin pulse_reload(); wait_idle(); end
        send_w(rand_vec()); send_w(rand_vec());
        pulse_reload();
      end
      load_kernel();
      nb = $urandom_range(1, 3*N);
      for (int b = 0; b < nb; b++) begin
        repeat ($urandom_range(0, 2)) tick();
        send_px(rand_vec(), w);
      end
    end
    rnd_rr = 0; tick(); bus.res_ready = 1'b1;
    repeat (20) tick();
    chk("all_results_seen", exp_q.size(), 0);

    // Asynchronous reset while a result is pending.
    for (int k = 0; k < N; k++) kw[k] = rand_vec();
    load_kernel();
    bus.res_ready = 1'b0;
    for (int b = 0; b < N; b++) send_px(rand_vec(), w);
    tick(); tick();
    chk("ar_pre_valid", bus.res_valid, 1);
    #2 rst_n = 1'b0; #1;
    chk("ar_res_valid", bus.res_valid, 0);
    chk("ar_res_data", bus.res_data, 0);
    chk("ar_busy", busy, 0);
    chk("ar_px_ready", bus.px_ready, 0);
    chk("ar_chunk_idx", chunk_idx, 0);
    chk("ar_mac_pixels", longint'(mac_pixels != '0), 0);
    chk("ar_mac_weights", longint'(mac_weights != '0), 0);
    @(negedge clk); rst_n = 1'b1; tick();
    chk("ar_w_ready", bus.w_ready, 1);
    chk("ar_busy_after", busy, 0);

    // Single-chunk kernels: one weight beat enters RUN, one result every two cycles.
    bus1.res_ready = 1'b1;
    bus1.w_valid = 1'b1; bus1.w_data = {LANES{8'h01}};
    @(negedge clk);
    chk("n1_w_ready", bus1.w_ready, 1);
    tick(); bus1.w_valid = 1'b0;
    chk("n1_busy", busy1, 1);
    chk("n1_run_no_w", bus1.w_ready, 0);
    bus1.px_valid = 1'b1; bus1.px_data = {LANES{8'h05}};
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus1.res_valid) begin cnt++; chk("n1_res", bus1.res_data, 80); end
    end
    chk("n1_rate", cnt, 4);
    bus1.px_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
